// File: rtl/mem_arbiter_if.sv
// Bundles the fetch port, data port and unified-memory port of mem_arbiter.
// slave = arbiter side, master = pipeline/memory side.
interface mem_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ready;
   logic        err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
      output if_rdata, if_ready, dm_rdata, dm_ready, err,
             mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
      input  if_rdata, if_ready, dm_rdata, dm_ready, err,
             mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data-memory requests onto one unified memory port.
// Data port has fixed priority; a stalled memory is cut off after WAIT_LIMIT cycles.
module mem_arbiter #(
   parameter int unsigned WAIT_LIMIT = 15
) (
   input  logic         clk,
   input  logic         reset_n,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, DM_BUSY, IF_BUSY, RESP} state_t;

   localparam logic [7:0] LIM_M1 = 8'(WAIT_LIMIT - 1);

   state_t      r_state,     w_state_nx;
   logic [7:0]  r_cnt,       w_cnt_nx;
   logic        r_mem_req,   w_mem_req_nx;
   logic        r_mem_we,    w_mem_we_nx;
   logic [31:0] r_mem_addr,  w_mem_addr_nx;
   logic [31:0] r_mem_wdata, w_mem_wdata_nx;
   logic [31:0] r_if_rdata,  w_if_rdata_nx;
   logic [31:0] r_dm_rdata,  w_dm_rdata_nx;
   logic        r_if_ready,  w_if_ready_nx;
   logic        r_dm_ready,  w_dm_ready_nx;
   logic        r_err,       w_err_nx;
   logic        w_done;
   logic [31:0] w_rd;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_if_rdata  <= '0;
         r_dm_rdata  <= '0;
         r_if_ready  <= 1'b0;
         r_dm_ready  <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_cnt       <= w_cnt_nx;
         r_mem_req   <= w_mem_req_nx;
         r_mem_we    <= w_mem_we_nx;
         r_mem_addr  <= w_mem_addr_nx;
         r_mem_wdata <= w_mem_wdata_nx;
         r_if_rdata  <= w_if_rdata_nx;
         r_dm_rdata  <= w_dm_rdata_nx;
         r_if_ready  <= w_if_ready_nx;
         r_dm_ready  <= w_dm_ready_nx;
         r_err       <= w_err_nx;
      end
   end

   always_comb begin
      w_state_nx     = r_state;
      w_cnt_nx       = r_cnt;
      w_mem_req_nx   = r_mem_req;
      w_mem_we_nx    = r_mem_we;
      w_mem_addr_nx  = r_mem_addr;
      w_mem_wdata_nx = r_mem_wdata;
      w_if_rdata_nx  = r_if_rdata;
      w_dm_rdata_nx  = r_dm_rdata;
      w_if_ready_nx  = 1'b0;
      w_dm_ready_nx  = 1'b0;
      w_err_nx       = 1'b0;
      // ack wins over a timeout landing in the same cycle
      w_done         = bus.mem_ack || (r_cnt == LIM_M1);
      w_rd           = bus.mem_ack ? bus.mem_rdata : 32'h0;

      unique case (r_state)
         IDLE: begin
            if (bus.dm_req) begin
               w_state_nx     = DM_BUSY;
               w_cnt_nx       = '0;
               w_mem_req_nx   = 1'b1;
               w_mem_we_nx    = bus.dm_we;
               w_mem_addr_nx  = bus.dm_addr;
               w_mem_wdata_nx = bus.dm_wdata;
            end else if (bus.if_req) begin
               w_state_nx     = IF_BUSY;
               w_cnt_nx       = '0;
               w_mem_req_nx   = 1'b1;
               w_mem_we_nx    = 1'b0;
               w_mem_addr_nx  = bus.if_addr;
               w_mem_wdata_nx = '0;
            end
         end
         DM_BUSY: begin
            if (w_done) begin
               w_state_nx    = RESP;
               w_mem_req_nx  = 1'b0;
               w_dm_ready_nx = 1'b1;
               w_err_nx      = !bus.mem_ack;
               w_dm_rdata_nx = r_mem_we ? 32'h0 : w_rd;
            end else begin
               w_cnt_nx = r_cnt + 8'd1;
            end
         end
         IF_BUSY: begin
            if (w_done) begin
               w_state_nx    = RESP;
               w_mem_req_nx  = 1'b0;
               w_if_ready_nx = 1'b1;
               w_err_nx      = !bus.mem_ack;
               w_if_rdata_nx = w_rd;
            end else begin
               w_cnt_nx = r_cnt + 8'd1;
            end
         end
         RESP: w_state_nx = IDLE;
         default: w_state_nx = IDLE;
      endcase
   end

   assign bus.mem_req   = r_mem_req;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.if_rdata  = r_if_rdata;
   assign bus.if_ready  = r_if_ready;
   assign bus.dm_rdata  = r_dm_rdata;
   assign bus.dm_ready  = r_dm_ready;
   assign bus.err       = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with WAIT_LIMIT=4: fetch, collision,
// store, timeout, ack-at-limit and reset mid-transaction.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   mem_arbiter_if bus ();

   mem_arbiter #(.WAIT_LIMIT(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // the two ready pulses must never coincide
   always @(negedge clk)
      if (reset_n) chk("ready_excl", 32'(bus.if_ready & bus.dm_ready), 32'h0);

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      bus.if_req = 0; bus.if_addr = 0; bus.dm_req = 0; bus.dm_we = 0;
      bus.dm_addr = 0; bus.dm_wdata = 0; bus.mem_rdata = 0; bus.mem_ack = 0;
      tick();
      chk("rst_mem_req", 32'(bus.mem_req), 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_if_ready", 32'(bus.if_ready), 0);
      chk("rst_dm_ready", 32'(bus.dm_ready), 0);
      chk("rst_err", 32'(bus.err), 0);
      chk("rst_dm_rdata", bus.dm_rdata, 0);
      reset_n = 1'b1;
      tick();

      // fetch only, ack in first busy cycle
      bus.if_req = 1; bus.if_addr = 32'h40;
      tick();
      chk("f_mem_req", 32'(bus.mem_req), 1);
      chk("f_mem_addr", bus.mem_addr, 32'h40);
      chk("f_mem_we", 32'(bus.mem_we), 0);
      chk("f_ready_early", 32'(bus.if_ready), 0);
      bus.mem_ack = 1; bus.mem_rdata = 32'h8C220004;
      tick();
      chk("f_if_ready", 32'(bus.if_ready), 1);
      chk("f_if_rdata", bus.if_rdata, 32'h8C220004);
      chk("f_err", 32'(bus.err), 0);
      chk("f_mem_req_off", 32'(bus.mem_req), 0);
      bus.if_req = 0; bus.mem_ack = 0;
      tick();
      chk("f_ready_pulse", 32'(bus.if_ready), 0);

      // simultaneous requests: data port first
      bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h100;
      bus.if_req = 1; bus.if_addr = 32'h44;
      tick();
      chk("s_dm_addr", bus.mem_addr, 32'h100);
      chk("s_dm_we", 32'(bus.mem_we), 0);
      bus.mem_ack = 1; bus.mem_rdata = 32'h11112222;
      tick();
      chk("s_dm_ready", 32'(bus.dm_ready), 1);
      chk("s_if_ready0", 32'(bus.if_ready), 0);
      chk("s_dm_rdata", bus.dm_rdata, 32'h11112222);
      chk("s_if_hold", bus.if_rdata, 32'h8C220004);
      bus.dm_req = 0; bus.mem_ack = 0;
      tick();
      chk("s_idle_req", 32'(bus.mem_req), 0);
      tick();
      chk("s_if_grant", 32'(bus.mem_req), 1);
      chk("s_if_addr", bus.mem_addr, 32'h44);
      bus.mem_ack = 1; bus.mem_rdata = 32'h33334444;
      tick();
      chk("s_if_ready", 32'(bus.if_ready), 1);
      chk("s_if_rdata", bus.if_rdata, 32'h33334444);
      chk("s_dm_hold", bus.dm_rdata, 32'h11112222);
      bus.if_req = 0; bus.mem_ack = 0;
      tick();

      // store, ack in fourth busy cycle
      bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h200; bus.dm_wdata = 32'hDEADBEEF;
      bus.mem_rdata = 32'h55555555;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("st_mem_req", 32'(bus.mem_req), 1);
         chk("st_mem_we", 32'(bus.mem_we), 1);
         chk("st_mem_addr", bus.mem_addr, 32'h200);
         chk("st_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
         chk("st_no_ready", 32'(bus.dm_ready), 0);
         if (i == 3) bus.mem_ack = 1;
      end
      tick();
      chk("st_dm_ready", 32'(bus.dm_ready), 1);
      chk("st_dm_rdata", bus.dm_rdata, 32'h0);
      chk("st_err", 32'(bus.err), 0);
      bus.dm_req = 0; bus.dm_we = 0; bus.mem_ack = 0;
      tick();

      // timeout: no ack at all
      bus.dm_req = 1; bus.dm_addr = 32'h300; bus.mem_rdata = 32'h99999999;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("to_mem_req", 32'(bus.mem_req), 1);
         chk("to_no_ready", 32'(bus.dm_ready), 0);
      end
      tick();
      chk("to_mem_req_off", 32'(bus.mem_req), 0);
      chk("to_dm_ready", 32'(bus.dm_ready), 1);
      chk("to_err", 32'(bus.err), 1);
      chk("to_dm_rdata", bus.dm_rdata, 32'h0);
      bus.dm_req = 0;
      tick();
      chk("to_idle_ready", 32'(bus.dm_ready), 0);
      chk("to_idle_err", 32'(bus.err), 0);
      chk("to_idle_req", 32'(bus.mem_req), 0);

      // ack on exactly the limit cycle
      bus.dm_req = 1; bus.dm_addr = 32'h400;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("bd_mem_req", 32'(bus.mem_req), 1);
         if (i == 3) begin
            bus.mem_ack = 1; bus.mem_rdata = 32'hCAFEF00D;
         end
      end
      tick();
      chk("bd_dm_ready", 32'(bus.dm_ready), 1);
      chk("bd_err", 32'(bus.err), 0);
      chk("bd_dm_rdata", bus.dm_rdata, 32'hCAFEF00D);
      bus.dm_req = 0; bus.mem_ack = 0;
      tick();

      // reset in second fetch busy cycle
      bus.if_req = 1; bus.if_addr = 32'h80;
      tick();
      chk("rs_busy1", 32'(bus.mem_req), 1);
      tick();
      chk("rs_busy2", 32'(bus.mem_req), 1);
      reset_n = 1'b0;
      #1;
      chk("rs_mem_req", 32'(bus.mem_req), 0);
      chk("rs_mem_addr", bus.mem_addr, 32'h0);
      chk("rs_if_rdata", bus.if_rdata, 32'h0);
      chk("rs_dm_rdata", bus.dm_rdata, 32'h0);
      bus.if_req = 0;
      tick();
      reset_n = 1'b1;
      tick();
      bus.mem_ack = 1; bus.mem_rdata = 32'h77777777;
      tick();
      chk("rs_if_ready", 32'(bus.if_ready), 0);
      chk("rs_dm_ready", 32'(bus.dm_ready), 0);
      chk("rs_if_rdata2", bus.if_rdata, 32'h0);
      chk("rs_err", 32'(bus.err), 0);
      chk("rs_mem_req2", 32'(bus.mem_req), 0);
      bus.mem_ack = 0;
      tick();
      chk("rs_if_ready2", 32'(bus.if_ready), 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_LIMIT, default 15: maximum mem_req cycles without mem_ack before the transaction is aborted; legal range 1..255.
REQ-002 clk  input  1  pipeline clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 if_req  input  1  fetch-stage read request; held high until if_ready.
REQ-005 if_addr  input  32  fetch word address (PCF); stable while if_req is high.
REQ-006 if_rdata  output  32  fetched instruction; valid only while if_ready is high.
REQ-007 if_ready  output  1  one-cycle completion pulse for fetch.
REQ-008 dm_req  input  1  memory-stage request; held high until dm_ready.
REQ-009 dm_we  input  1  1 = store, 0 = load; stable while dm_req is high.
REQ-010 dm_addr  input  32  data address (ALUOutM); stable while dm_req is high.
REQ-011 dm_wdata  input  32  store data (WriteDataM); stable while dm_req is high.
REQ-012 dm_rdata  output  32  load data; valid only while dm_ready is high.
REQ-013 dm_ready  output  1  one-cycle completion pulse for the data port.
REQ-014 err  output  1  high together with a ready pulse when that transaction timed out.
REQ-015 mem_req  output  1  unified-memory request; registered.
REQ-016 mem_we  output  1  unified-memory write enable; registered.
REQ-017 mem_addr  output  32  unified-memory address; registered.
REQ-018 mem_wdata  output  32  unified-memory write data; registered.
REQ-019 mem_rdata  input  32  memory read data; valid in the mem_ack cycle.
REQ-020 mem_ack  input  1  memory completion; sampled only while mem_req is high.

Function
REQ-021 The FSM SHALL have four states: IDLE, DM_BUSY, IF_BUSY and RESP.
REQ-022 In IDLE with dm_req=1, the block SHALL move to DM_BUSY and latch dm_we, dm_addr and dm_wdata into the mem_* registers.
REQ-023 In IDLE with dm_req=0 and if_req=1, the block SHALL move to IF_BUSY with mem_we=0, mem_addr=if_addr and mem_wdata=0.
REQ-024 When dm_req and if_req are both high in IDLE, the data port SHALL win: fixed priority, because the older instruction goes first.
REQ-025 mem_req SHALL be 1 exactly while the state is DM_BUSY or IF_BUSY.
REQ-026 mem_we, mem_addr and mem_wdata SHALL hold their values for the whole busy period.
REQ-027 In a busy state, mem_ack=1 SHALL cause a move to RESP.
  - mem_rdata is captured into the granted port's rdata register.
  - err is set to 0.
REQ-028 In RESP, the block SHALL pulse the granted port's ready for exactly one cycle, then return to IDLE.
REQ-029 Requests seen during RESP SHALL NOT be granted; the requester's req may still be high in that cycle.
REQ-030 Minimum latency SHALL be 2 cycles from the req-sampled edge to the ready cycle when mem_ack is returned in the first mem_req cycle.
REQ-031 A busy-cycle counter SHALL clear on entry to a busy state and increment each busy cycle that has mem_ack=0.
REQ-032 When the counter reaches WAIT_LIMIT, the block SHALL move to RESP with err=1 and the granted rdata=0.
REQ-033 mem_ack in the same cycle the counter reaches WAIT_LIMIT SHALL win: normal completion, err=0.
REQ-034 For a store (mem_we=1), dm_rdata SHALL be 0 in the dm_ready cycle.
REQ-035 The rdata of the port that is not granted SHALL hold its previous value; its ready SHALL stay 0.
REQ-036 if_ready and dm_ready SHALL never be high in the same cycle.
REQ-037 mem_ack while mem_req=0 SHALL be ignored.
REQ-038 An IF request arriving while DM_BUSY SHALL wait; it is granted from IDLE only when no dm_req is present that cycle.
  - Fetch starvation under continuous dm_req is accepted, because the hazard logic stalls fetch during memory-stage stalls.

Reset
REQ-039 Asserting reset_n=0 SHALL immediately force:
  - state IDLE and counter 0;
  - mem_req, mem_we, if_ready, dm_ready and err to 0;
  - mem_addr, mem_wdata, if_rdata and dm_rdata to 0.
REQ-040 Reset during a busy state SHALL abandon the transaction with no ready pulse; a mem_ack arriving after reset SHALL be ignored.
REQ-041 After deassertion, the first grant SHALL occur on the first rising edge at which a request is sampled.

Verification
REQ-042 The bench SHALL cover a fetch only: if_req=1 and if_addr=0x00000040, with mem_ack returned in the first mem_req cycle -> mem_addr=0x40, mem_we=0; if_ready pulses 2 cycles after the req edge with if_rdata = mem_rdata (0x8C220004).
REQ-043 The bench SHALL cover a simultaneous request: dm_req (load, 0x100) and if_req (0x44) in the same cycle -> the DM transaction completes first, then the IF transaction is granted in the cycle after IDLE is re-entered; the ready pulses never overlap.
REQ-044 The bench SHALL cover a store: dm_we=1, dm_addr=0x200, dm_wdata=0xDEADBEEF, with mem_ack delayed 3 cycles -> mem_* stay stable for 4 cycles; dm_ready=1, dm_rdata=0, err=0.
REQ-045 The bench SHALL cover a timeout: WAIT_LIMIT=4 and mem_ack never returned -> mem_req is high for 4 cycles, then dm_ready=1, err=1, dm_rdata=0, and the FSM returns to IDLE.
REQ-046 The bench SHALL cover reset mid-transaction: reset_n driven low in the second IF_BUSY cycle -> mem_req=0 immediately; no if_ready pulse; a later mem_ack pulse causes no output change.
REQ-047 The bench SHALL cover a boundary: mem_ack on exactly the WAIT_LIMIT cycle -> normal completion with err=0 and the captured rdata.
